// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing decoder. It rebuilds pixel coordinates from the hsync/vsync
// edges, checks every edge against the nominal timing, and reports lock and errors.
module vga_sync_monitor #(
    parameter int   H_VIS       = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VIS       = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_POL    = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       h_err,
    output logic       v_err,
    output logic [7:0] err_cnt
);
    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int TO_TICKS = 2 * H_TOT;
    localparam int TW       = $clog2(TO_TICKS);
    localparam int GW       = $clog2(LOCK_FRAMES + 1);

    localparam logic [9:0]    H_LAST    = 10'(H_TOT - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOT - 1);
    localparam logic [9:0]    H_LEAD    = 10'(H_VIS + H_FP);
    localparam logic [9:0]    H_TRAIL   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]    V_LEAD    = 10'(V_VIS + V_FP);
    localparam logic [9:0]    V_TRAIL   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0]    H_VIS_W   = 10'(H_VIS);
    localparam logic [9:0]    V_VIS_W   = 10'(V_VIS);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_TICKS - 1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t        state_reg;
    logic [9:0]    hpos_reg, vpos_reg;
    logic [1:0]    sync_d_reg;
    logic [TW-1:0] to_cnt_reg;
    logic [GW-1:0] good_cnt_reg;
    logic          frame_err_reg;

    // Bit 0 carries hsync, bit 1 carries vsync; both are normalised to 1 = active.
    logic [1:0] sync_in, sync_act, lead, trail;
    assign sync_in = {vsync, hsync};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            assign sync_act[gi] = sync_in[gi] ~^ SYNC_POL;
            assign lead[gi]     = sync_act[gi] & ~sync_d_reg[gi];
            assign trail[gi]    = ~sync_act[gi] & sync_d_reg[gi];
        end
    endgenerate

    logic [9:0]    hn, vn;
    logic          checking, h_bad, v_bad, any_bad, timeout;
    logic [8:0]    err_sum;
    logic [GW-1:0] good_inc;

    always_comb begin
        hn = (hpos_reg == H_LAST) ? 10'd0 : hpos_reg + 10'd1;
        vn = vpos_reg;
        if (hpos_reg == H_LAST) begin
            vn = (vpos_reg == V_LAST) ? 10'd0 : vpos_reg + 10'd1;
        end
    end

    assign checking = (state_reg != SEARCH);
    assign h_bad    = checking & ((lead[0] & (hn != H_LEAD)) | (trail[0] & (hn != H_TRAIL)));
    assign v_bad    = checking & ((lead[1]  & ((hn != 10'd0) | (vn != V_LEAD))) |
                                  (trail[1] & ((hn != 10'd0) | (vn != V_TRAIL))));
    assign any_bad  = h_bad | v_bad;
    assign timeout  = ~lead[0] & (to_cnt_reg == TO_LAST);
    assign err_sum  = {1'b0, err_cnt} + {8'd0, h_bad} + {8'd0, v_bad};
    assign good_inc = good_cnt_reg + GW'(1);

    assign pixel_x  = hpos_reg;
    assign pixel_y  = vpos_reg;
    assign locked   = (state_reg == LOCKED);
    assign video_on = locked & (hpos_reg < H_VIS_W) & (vpos_reg < V_VIS_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= SEARCH;
            hpos_reg      <= '0;
            vpos_reg      <= '0;
            sync_d_reg    <= '0;
            to_cnt_reg    <= '0;
            good_cnt_reg  <= '0;
            frame_err_reg <= 1'b0;
            frame_start   <= 1'b0;
            h_err         <= 1'b0;
            v_err         <= 1'b0;
            err_cnt       <= '0;
        end else begin
            frame_start <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            if (p_tick) begin
                sync_d_reg  <= sync_act;
                hpos_reg    <= lead[0] ? H_LEAD : hn;
                vpos_reg    <= lead[1] ? V_LEAD : vn;
                frame_start <= lead[1];
                h_err       <= h_bad;
                v_err       <= v_bad;
                err_cnt     <= err_sum[8] ? 8'hFF : err_sum[7:0];

                if (lead[0] || timeout) begin
                    to_cnt_reg <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + TW'(1);
                end

                // Frame cleanliness is judged from one vsync leading edge to the next.
                if (lead[1]) begin
                    frame_err_reg <= 1'b0;
                end else if (any_bad) begin
                    frame_err_reg <= 1'b1;
                end

                if (timeout) begin
                    state_reg    <= SEARCH;
                    good_cnt_reg <= '0;
                end else begin
                    case (state_reg)
                        SEARCH: begin
                            if (lead[1]) begin
                                state_reg    <= ACQUIRE;
                                good_cnt_reg <= '0;
                            end
                        end
                        ACQUIRE: begin
                            if (lead[1]) begin
                                if (frame_err_reg || any_bad) begin
                                    good_cnt_reg <= '0;
                                end else if (good_inc == GOOD_LOCK) begin
                                    state_reg    <= LOCKED;
                                    good_cnt_reg <= '0;
                                end else begin
                                    good_cnt_reg <= good_inc;
                                end
                            end
                        end
                        LOCKED: begin
                            if (any_bad) begin
                                state_reg    <= ACQUIRE;
                                good_cnt_reg <= '0;
                            end
                        end
                        default: begin
                            state_reg    <= SEARCH;
                            good_cnt_reg <= '0;
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a reduced 25x15 raster. The driver pushes
// hand-computed expectations keyed by tick number, and the monitor checks them.
`timescale 1ns/1ps
module tb_vga_sync_monitor;
    localparam int HV = 16, HFP = 2, HSW = 4, HBP = 3;
    localparam int VV = 8,  VFP = 2, VSW = 2, VBP = 3;
    localparam int HT = HV + HFP + HSW + HBP;   // 25
    localparam int VT = VV + VFP + VSW + VBP;   // 15
    localparam int HL = HV + HFP;               // hsync leading edge column, 18
    localparam int HE = HL + HSW;               // hsync trailing edge column, 22
    localparam int VL = VV + VFP;               // vsync leading edge line, 10

    localparam int F_PX = 0, F_PY = 1, F_VON = 2, F_LOCK = 3;
    localparam int F_FS = 4, F_HERR = 5, F_VERR = 6, F_ECNT = 7;

    logic       clk = 1'b0;
    logic       reset, p_tick, hsync, vsync;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, locked, frame_start, h_err, v_err;
    logic [7:0] err_cnt;

    vga_sync_monitor #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .locked(locked),
        .frame_start(frame_start), .h_err(h_err), .v_err(v_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tick;
        int off;    // negedge index after the tick; -1 = next negedge
        int fld;
        int val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;
    int   tick_no = 0, mon_tick = 0, neg_cnt = 0;

    // Generator state of the stimulus stream.
    int gh, gv, gap;
    bit kill_h, short_h, hold, skip_v;

    function automatic string fname(int f);
        case (f)
            F_PX:    return "pixel_x";
            F_PY:    return "pixel_y";
            F_VON:   return "video_on";
            F_LOCK:  return "locked";
            F_FS:    return "frame_start";
            F_HERR:  return "h_err";
            F_VERR:  return "v_err";
            default: return "err_cnt";
        endcase
    endfunction

    function automatic int actual(int f);
        case (f)
            F_PX:    return int'(pixel_x);
            F_PY:    return int'(pixel_y);
            F_VON:   return int'(video_on);
            F_LOCK:  return int'(locked);
            F_FS:    return int'(frame_start);
            F_HERR:  return int'(h_err);
            F_VERR:  return int'(v_err);
            default: return int'(err_cnt);
        endcase
    endfunction

    // Monitor: counts ticks on the active edge, compares on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (p_tick && !reset) begin
                mon_tick++;
                neg_cnt = 0;
            end else begin
                neg_cnt++;
            end
            @(negedge clk);
            while (sb.size() > 0 && (sb[0].tick < mon_tick ||
                   (sb[0].tick == mon_tick && sb[0].off >= 0 && sb[0].off < neg_cnt))) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s tick %0d: never sampled, expected %0d",
                         fname(sb[0].fld), sb[0].tick, sb[0].val);
                void'(sb.pop_front());
            end
            while (sb.size() > 0 && sb[0].tick == mon_tick &&
                   (sb[0].off < 0 || sb[0].off == neg_cnt)) begin
                n_checks++;
                if (actual(sb[0].fld) != sb[0].val) begin
                    n_fail++;
                    $display("FAIL %s tick %0d off %0d: got %0d, expected %0d",
                             fname(sb[0].fld), sb[0].tick, sb[0].off,
                             actual(sb[0].fld), sb[0].val);
                end
                void'(sb.pop_front());
            end
        end
    end

    task automatic push(input int off, input int fld, input int val);
        exp_t e;
        e.tick = tick_no + 1;
        e.off  = off;
        e.fld  = fld;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic push_now(input int fld, input int val);
        exp_t e;
        e.tick = tick_no;
        e.off  = -1;
        e.fld  = fld;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic expect_all_zero();
        for (int f = 0; f < 8; f++) push_now(f, 0);
    endtask

    // Issue one pixel tick of the generated stream (active-low syncs), then advance.
    task automatic step();
        bit ha, va;
        ha = !kill_h && gh >= HL && gh < (short_h ? HE - 1 : HE);
        va = gv >= VL && gv < VL + VSW;
        hsync  = ~ha;
        vsync  = ~va;
        p_tick = 1'b1;
        tick_no++;
        @(posedge clk);
        #1 p_tick = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk);
            #1;
        end
        if (!hold) begin
            gh++;
            if (gh == HT) begin
                gh = 0;
                gv = (skip_v && gv == VL - 2) ? VL : gv + 1;
                if (gv == VT) gv = 0;
            end
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(gh == h && (v < 0 || gv == v))) begin
            step();
            n++;
            if (n > 2 * HT * VT) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_to(%0d,%0d): target not reached", h, v);
                return;
            end
        end
    endtask

    // Next vsync leading edge: frame_start pulse, lock state and error count.
    task automatic exp_vl(input int lk, input int ec);
        run_to(0, VL);
        push(0, F_FS, 1);
        push(0, F_LOCK, lk);
        push(0, F_ECNT, ec);
        push(1, F_FS, 0);
        step();
    endtask

    int sat_n[4] = '{1, 251, 252, 300};
    int sat_e[4] = '{4, 254, 255, 255};

    initial begin
        reset = 1'b1; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1;
        kill_h = 0; short_h = 0; hold = 0; skip_v = 0; gap = 4;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        expect_all_zero();

        // Compliant stream starting mid-frame: lock on the third vsync leading edge.
        gh = 5; gv = 3;
        exp_vl(0, 0);
        exp_vl(0, 0);
        exp_vl(1, 0);
        run_to(0, 0);
        push(0, F_PX, 0); push(0, F_PY, 0); push(0, F_VON, 1);
        step();
        run_to(HV - 1, VV - 1);
        push(0, F_PX, HV - 1); push(0, F_PY, VV - 1); push(0, F_VON, 1);
        step();
        push(0, F_VON, 0); push(0, F_PX, HV);
        step();

        // Late hsync leading edge: stream slips by one tick before the edge.
        run_to(HL - 1, 3);
        push(0, F_LOCK, 1);
        hold = 1; step(); hold = 0;
        step();
        push(0, F_HERR, 1); push(0, F_LOCK, 0); push(0, F_ECNT, 1); push(0, F_PX, HL);
        push(1, F_HERR, 0);
        step();
        exp_vl(0, 1);
        exp_vl(0, 1);
        exp_vl(1, 1);

        // Hsync pulse one tick short: error at the trailing edge.
        run_to(0, 4);
        short_h = 1;
        run_to(HE - 1, 4);
        push(0, F_HERR, 1); push(0, F_LOCK, 0); push(0, F_ECNT, 2); push(1, F_HERR, 0);
        step();
        short_h = 0;

        // Vsync one line early (line VL-1 skipped by the source).
        skip_v = 1;
        run_to(0, VL);
        push(0, F_VERR, 1); push(0, F_FS, 1); push(0, F_PY, VL); push(0, F_HERR, 0);
        push(0, F_ECNT, 3); push(1, F_VERR, 0);
        step();
        skip_v = 0;
        exp_vl(0, 3);
        exp_vl(1, 3);

        // Lost hsync: last leading edge at (HL,14); timeout on the 50th tick after it.
        run_to(0, 0);
        push(0, F_VON, 1); push(0, F_LOCK, 1);
        step();
        kill_h = 1;
        run_to(HL - 1, 1);
        push(0, F_LOCK, 1);
        step();
        push(0, F_LOCK, 0);
        step();
        run_to(5, 2);
        push(0, F_VON, 0); push(0, F_LOCK, 0);
        step();
        kill_h = 0;
        exp_vl(0, 3);
        exp_vl(0, 3);
        exp_vl(1, 3);

        // Saturation: one short hsync pulse per line, ticking every clk.
        gap = 1;
        short_h = 1;
        for (int n = 1; n <= 300; n++) begin
            run_to(HE - 1, -1);
            for (int k = 0; k < 4; k++) begin
                if (sat_n[k] == n) begin
                    push(0, F_HERR, 1);
                    push(0, F_ECNT, sat_e[k]);
                end
            end
            step();
        end
        short_h = 0;
        gap = 4;

        // Reset mid-line clears everything.
        run_to(7, -1);
        push(0, F_PX, 7); push(0, F_ECNT, 255);
        step();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        expect_all_zero();

        repeat (10) @(posedge clk);
        while (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s tick %0d: still pending at end, expected %0d",
                     fname(sb[0].fld), sb[0].tick, sb[0].val);
            void'(sb.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side decoder for the VGA timing that the sync generator produces. It samples incoming `hsync`/`vsync` on pixel ticks and rebuilds pixel coordinates and data-enable from the sync edges alone. It checks every edge against the 640x480@60 timing and reports a lock status, error pulses and a saturating error count. It sits beside the sync generator on the 25 MHz pixel-tick domain and serves as an on-chip loopback checker and as the front end for any downstream frame-capture logic.

## Interface
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (ticks)
- `H_SYNC`, 96, hsync pulse width (ticks)
- `H_BP`, 48, horizontal back porch (ticks)
- `V_VIS`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 1'b0, active level of both syncs (0 = active-low)
- `LOCK_FRAMES`, 2, consecutive clean frames required to lock

Ports:
- `clk`  in  1  system clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- `p_tick`  in  1  pixel strobe, one `clk` wide; the only cycles on which state advances
- `hsync`  in  1  horizontal sync, polarity per `SYNC_POL`
- `vsync`  in  1  vertical sync, polarity per `SYNC_POL`
- `pixel_x`  out  10  reconstructed horizontal position
- `pixel_y`  out  10  reconstructed vertical position
- `video_on`  out  1  `locked` and `pixel_x` < `H_VIS` and `pixel_y` < `V_VIS`
- `locked`  out  1  timing verified
- `frame_start`  out  1  one-clk pulse on each vsync leading edge
- `h_err`  out  1  one-clk pulse on a horizontal timing violation
- `v_err`  out  1  one-clk pulse on a vertical timing violation
- `err_cnt`  out  8  total violations, saturates at 255, cleared only by `reset`

## Operation
- **Constants.** H_TOT = `H_VIS`+`H_FP`+`H_SYNC`+`H_BP` (800). V_TOT analogously (525).
- **Sync conditioning.** `hs`/`vs` = input XNOR `SYNC_POL` (1 = active). Both are registered on `p_tick`.
- **Edge definitions.** A leading edge is `hs` & ~`hs_d`. A trailing edge is ~`hs` & `hs_d`. `vsync` is treated the same way.
- **Next position, each tick.**
  - hn = (hpos==H_TOT-1) ? 0 : hpos+1.
  - vn = (hpos==H_TOT-1) ? ((vpos==V_TOT-1) ? 0 : vpos+1) : vpos.
- **Resynchronisation, every state.**
  - hsync leading edge: hpos <= `H_VIS`+`H_FP` (656). Otherwise hpos <= hn.
  - vsync leading edge: vpos <= `V_VIS`+`V_FP` (490). Otherwise vpos <= vn.
- **Checks** (evaluated only in ACQUIRE and LOCKED; any failure raises `h_err`/`v_err`):
  - hsync leading edge requires hn==656.
  - hsync trailing edge requires hn==`H_VIS`+`H_FP`+`H_SYNC` (752).
  - vsync leading edge requires hn==0 and vn==490.
  - vsync trailing edge requires hn==0 and vn==492.
  - Simultaneous `h_err` and `v_err` add 2 to `err_cnt` (subject to saturation).
- **FSM states:** SEARCH, ACQUIRE, LOCKED.
  - SEARCH: first vsync leading edge → ACQUIRE, good_cnt=0.
  - ACQUIRE: on vsync leading edge, a frame with no error since the previous leading edge increments good_cnt. When good_cnt reaches `LOCK_FRAMES`, go to LOCKED. A frame with an error clears good_cnt.
  - LOCKED: any `h_err`/`v_err` → ACQUIRE, good_cnt=0.
  - Timeout, any state: 2*H_TOT ticks with no hsync leading edge → SEARCH, `locked`=0.
- `locked` = (state==LOCKED).

## Timing
- **Reset values.** All outputs 0; hpos, vpos, good_cnt and the timeout counter are 0; `hs_d`/`vs_d`=0; state SEARCH. Reset mid-frame discards all tracking.
- **Latency.** Sync inputs sampled on a `p_tick` cycle are reflected in `pixel_x`/`pixel_y`/`video_on` on the next `clk`. Flags and `locked` update in that same cycle.
- **Hold between ticks.** With `p_tick` low, all outputs hold, except that `frame_start`, `h_err` and `v_err` return to 0.
- **Error attribution.** A violation on the lock-achieving vsync edge blocks lock for that edge.
- **Wrap-around.** hpos wraps 799→0, with vpos incrementing in the same tick. vpos wraps 524→0.

## Test plan
- **Compliant lock.** Drive a compliant 800x525 stream, `p_tick` every 4th clk, starting mid-frame.
  - `locked` rises one clk after the 3rd vsync leading edge.
  - First visible pixel gives `pixel_x`=0, `pixel_y`=0, `video_on`=1.
  - Last visible pixel gives (639, 479).
  - `err_cnt` stays 0.
- **Late hsync while LOCKED.** Delay one hsync leading edge by 1 tick.
  - `h_err` pulses and `locked` drops; `err_cnt`=1.
  - `pixel_x`=656 on the next clk.
  - `locked` returns after 2 clean frames.
- **Short hsync pulse.** Hsync pulse of 95 ticks → `h_err` at the trailing edge, `err_cnt` increments by 1.
- **Early vsync.** Vsync leading edge one line early (vn==489).
  - `v_err` and `frame_start` pulse together.
  - `pixel_y`=490 on the next clk.
- **Lost hsync.** Hold hsync inactive.
  - After 1600 ticks the FSM is in SEARCH, `locked`=0 and `video_on`=0.
  - Restore the stream → relock after the 3rd vsync edge.
- **Saturation and reset.**
  - Inject 300 hsync errors → `err_cnt`=255.
  - Assert `reset` mid-line → all outputs 0 on the next clk.
